instr_fetch: RTL

//  Instruction fetch stage feeding the instruction decoder/control unit. Holds the PC,

---
 rtl/instr_fetch.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
// Holds the PC, fetches one 18-bit word at a time over a req/ack memory port and
// presents it to the decoder with a valid/ready handshake. Control redirects
// (jump/call/ret) reload the PC; an outstanding memory request is drained first.
// Optional feature: define FETCH_RAS_EN to add a circular hardware return-address
// stack (RAS_DEPTH entries, power of two, at least 2).
module instr_fetch #(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     INSTR_W   = 18,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_addr,
    input  logic               call_in,
    input  logic               ret_in
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               imem_req_q, imem_req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;

    // The decoder takes the held word this cycle.
    logic               consume;
    // Effective redirect after the RAS (if present) has had its say.
    logic               redir_take;
    logic [PC_W-1:0]    redir_target;

    assign consume = instr_valid_q & instr_ready;

`ifdef FETCH_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;

    // ras_ptr points at the next free slot; the top of stack sits just below it.
    assign ras_top  = ras_ptr_q - PTR_W'(1);
    // A RET with a non-empty stack wins over a simultaneous CALL.
    assign ras_pop  = consume & ret_in & (ras_cnt_q != '0);
    assign ras_push = consume & call_in & ~ret_in;

    assign redir_take   = redirect | ras_pop;
    assign redir_target = ras_pop ? ras_mem[ras_top] : redirect_addr;

    // Stack pointer/occupancy update; a push when full wraps over the oldest entry.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_pop) begin
            ras_ptr_d = ras_top;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end else if (ras_push) begin
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end
    end

    // Return-address storage: write the address after the CALL on a push.
    // NOTE: storage has no reset; ras_cnt gates every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr_q] <= instr_pc_q + PC_W'(1);
        end
    end

    // Stack pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    // Without the stack, CALL/RET hints are ignored and control uses redirect only.
    logic unused_ras_hints;
    assign unused_ras_hints = call_in ^ ret_in;
    assign redir_take       = redirect;
    assign redir_target     = redirect_addr;
`endif

    // Next-state and next-output logic for the fetch FSM; outputs follow the next state.
    always_comb begin
        // NOTE: every _d gets a hold default up front, so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;

        unique case (state_q)
            S_BOOT: begin
                state_d     = S_REQ;
                pc_d        = redir_take ? redir_target : pc_q;
                imem_addr_d = redir_take ? redir_target : pc_q;
            end
            S_REQ: begin
                if (redir_take) begin
                    pc_d = redir_target;
                    if (imem_ack) begin
                        // Returned word belongs to the old path: drop it, refetch now.
                        state_d     = S_REQ;
                        imem_addr_d = redir_target;
                    end else begin
                        // Request still in flight: keep the old address until it completes.
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    state_d    = S_HOLD;
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + PC_W'(1);
                end
            end
            S_HOLD: begin
                if (redir_take) begin
                    state_d     = S_REQ;
                    pc_d        = redir_target;
                    imem_addr_d = redir_target;
                end else if (instr_ready) begin
                    state_d     = S_REQ;
                    imem_addr_d = pc_q;
                end
            end
            S_DRAIN: begin
                pc_d = redir_take ? redir_target : pc_q;
                if (imem_ack) begin
                    state_d     = S_REQ;
                    imem_addr_d = redir_take ? redir_target : pc_q;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        imem_req_d    = (state_d == S_REQ) || (state_d == S_DRAIN);
        instr_valid_d = (state_d == S_HOLD);
    end

    // FSM state, PC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule
